// File: rtl/fetch_unit.sv
// Fetch stage of the pipelined MIPS core: owns the PC, selects next-PC and drives the
// synchronous instruction BRAM, presenting instruction, PC+8 and fetch cause to F/D.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFC,
  parameter int          IM_AW      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_en,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_f,
  output logic [31:0]      pc8_f,
  output logic [31:0]      cause_f
);

  localparam logic [31:0] CAUSE_ADEL = 32'h0000_0010;  // ExcCode 4 in bits [6:2]

  logic [31:0] next_pc;
  logic        next_adel;
  logic [31:0] pc_q;
  logic [31:0] pc8_q;
  logic [31:0] cause_q;
  logic        adel_q;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // value on every path, so no latch can be inferred.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (!rst)                next_pc = RESET_PC;
    else if (exc_req)        next_pc = HANDLER_PC;
    else if (eret_req)       next_pc = epc;
    else if (!f_en)          next_pc = pc_q;
    else if (redirect_valid) next_pc = redirect_pc;
  end

  assign next_adel = (next_pc[1:0] != 2'b00) || (next_pc < IM_BASE) || (next_pc > IM_TOP);

  // Driven straight from next_pc: the BRAM is the only register on the instruction path,
  // so its output in a cycle belongs to the pc_f of that same cycle.
  assign im_addr = next_pc[IM_AW+1:2];

  // Reset is folded into the next_pc mux, so every register picks up its reset value
  // on the same synchronous edge without a separate reset branch here.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    pc_q    <= next_pc;
    pc8_q   <= next_pc + 32'd8;
    adel_q  <= next_adel;
    cause_q <= next_adel ? CAUSE_ADEL : 32'h0;
  end

  assign pc_f    = pc_q;
  assign pc8_f   = pc8_q;
  assign cause_f = cause_q;
  assign instr_f = adel_q ? 32'h0 : im_rdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a synchronous BRAM model plus a scoreboard of
// expected F-stage outputs pushed when each cycle's inputs are driven.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] pc8_f;
  logic [31:0] cause_f;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic [31:0] cause;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] mem [4096];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .f_en          (f_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .im_addr       (im_addr),
    .im_rdata      (im_rdata),
    .pc_f          (pc_f),
    .instr_f       (instr_f),
    .pc8_f         (pc8_f),
    .cause_f       (cause_f)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_rdata <= mem[im_addr];

  function automatic logic [31:0] word_at(input logic [11:0] a);
    return {8'hA5, a, a ^ 12'h5A3};
  endfunction

  function automatic exp_t expect_for(input logic [31:0] pc);
    exp_t e;
    logic bad;
    bad     = (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
    e.pc    = pc;
    e.pc8   = pc + 32'd8;
    e.instr = bad ? 32'h0 : word_at(pc[13:2]);
    e.cause = bad ? 32'h10 : 32'h0;
    return e;
  endfunction

  // One clock: drive inputs at the negedge, check im_addr combinationally, then check
  // the registered outputs at the following negedge against the scoreboard entry.
  task automatic cycle(input string name, input logic r, input logic fe, input logic rv,
                       input logic [31:0] rp, input logic ex, input logic er,
                       input logic [31:0] ep, input logic [31:0] exp_pc);
    exp_t e;
    logic [31:0] next_pc_exp;
    rst = r; f_en = fe; redirect_valid = rv; redirect_pc = rp;
    exc_req = ex; eret_req = er; epc = ep;
    sb_q.push_back(expect_for(exp_pc));
    next_pc_exp = exp_pc;
    #1;
    tests++;
    if (im_addr !== next_pc_exp[13:2]) begin
      fails++;
      $display("FAIL %s im_addr: got %h want %h", name, im_addr, next_pc_exp[13:2]);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      e = sb_q.pop_front();
      tests += 3;
      if (pc_f !== e.pc) begin
        fails++; $display("FAIL %s pc_f: got %h want %h", name, pc_f, e.pc);
      end
      if (pc8_f !== e.pc8) begin
        fails++; $display("FAIL %s pc8_f: got %h want %h", name, pc8_f, e.pc8);
      end
      if (cause_f !== e.cause) begin
        fails++; $display("FAIL %s cause_f: got %h want %h", name, cause_f, e.cause);
      end
      if (instr_f !== e.instr) begin
        fails++; $display("FAIL %s instr_f: got %h want %h", name, instr_f, e.instr);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      cycle("reset", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3000);
  endtask

  task automatic test_sequential();
    cycle("seq0", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3004);
    cycle("seq1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3008);
  endtask

  task automatic test_stall();
    cycle("stall0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3008);
    cycle("stall1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3008);
    cycle("resume", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h300C);
  endtask

  task automatic test_redirect();
    cycle("redir",       1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 32'h3100);
    cycle("redir_stall", 1'b1, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b0, 32'h0, 32'h3100);
    cycle("redir_after", 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 32'h3104);
  endtask

  task automatic test_bad_pc();
    cycle("misalign",     1'b1, 1'b1, 1'b1, 32'h3002, 1'b0, 1'b0, 32'h0, 32'h3002);
    cycle("misalign_inc", 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 32'h3006);
    cycle("below_base",   1'b1, 1'b1, 1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0, 32'h2FFC);
    cycle("into_base",    1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 32'h3000);
    cycle("top_edge",     1'b1, 1'b1, 1'b1, 32'h6FFC, 1'b0, 1'b0, 32'h0, 32'h6FFC);
    cycle("above_top",    1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 32'h7000);
    cycle("wrap_pc8",     1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
  endtask

  task automatic test_exception();
    cycle("exc_stall_redir", 1'b1, 1'b0, 1'b1, 32'h3100, 1'b1, 1'b0, 32'h0,    32'h4180);
    cycle("exc_vs_eret",     1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3040, 32'h4180);
    cycle("handler_inc",     1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h4184);
  endtask

  task automatic test_eret();
    cycle("eret",        1'b1, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b1, 32'h3040, 32'h3040);
    cycle("eret_rst",    1'b0, 1'b1, 1'b1, 32'h3100, 1'b1, 1'b1, 32'h3040, 32'h3000);
    cycle("post_rst",    1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h3004);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = word_at(i[11:0]);
    rst = 1'b0; f_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_bad_pc();
    test_exception();
    test_eret();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch (F) stage of the pipelined MIPS core. It owns the PC register and next-PC selection, and drives the synchronous block-RAM instruction memory.
- Its outputs feed the F/D pipeline register: the fetched instruction, PC+8 and a fetch-exception cause word.
- It honours the same stall and exception-redirect signals that the F/D register uses, so both ends of the F→D interface move in lockstep.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded while reset is active.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive).
- IM_AW, 12, word-address width driven to the IM block RAM.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-low.
- f_en, input, 1, fetch enable; 0 = stall, so PC holds.
- redirect_valid, input, 1, branch or jump resolved in D and taken.
- redirect_pc, input, 32, branch or jump target.
- exc_req, input, 1, CP0 exception/interrupt entry request.
- eret_req, input, 1, eret resolved in D.
- epc, input, 32, return address for eret.
- im_addr, output, IM_AW, BRAM word address, = next_pc[IM_AW+1:2].
- im_rdata, input, 32, BRAM read data, valid one cycle after im_addr.
- pc_f, output, 32, current fetch PC.
- instr_f, output, 32, fetched instruction.
- pc8_f, output, 32, pc_f + 8.
- cause_f, output, 32, fetch exception cause.

Behaviour:
- next_pc selection, highest priority first:
  - rst==0 → RESET_PC.
  - exc_req → HANDLER_PC.
  - eret_req → epc.
  - f_en==0 → pc_f (hold).
  - redirect_valid → redirect_pc.
  - otherwise pc_f + 4.
- exc_req and eret_req override a stall. A redirect during a stall is dropped, because the branch is still held in D and re-asserts redirect_valid once the stall clears.
- Updates:
  - pc_f <= next_pc on every posedge clk.
  - im_addr is driven combinationally from next_pc, so the BRAM output at cycle N corresponds to pc_f at cycle N.
  - A stall re-reads the same address, so instr_f is stable while stalled. No skid register is needed.
- Reset:
  - While rst==0, im_addr = RESET_PC[IM_AW+1:2].
  - In the first cycle after reset is released: pc_f = 32'h3000, pc8_f = 32'h3008, instr_f = word at 0x3000.
  - Reset values of the registered outputs: pc_f = RESET_PC, pc8_f = RESET_PC + 8, cause_f = 0.
- pc8_f: pc_f + 8 with 32-bit wrap-around and no overflow detection.
- Address check (combinational on pc_f): adel = (pc_f[1:0] != 0) || (pc_f < IM_BASE) || (pc_f > IM_TOP), using unsigned compares.
- adel==1:
  - instr_f = 32'h0 (nop).
  - cause_f = 32'h0000_0010, i.e. ExcCode 4 in bits[6:2], all other bits 0.
- adel==0: instr_f = im_rdata, cause_f = 0.
- A bad PC keeps incrementing by 4 until CP0 asserts exc_req. The block does not self-redirect on adel.
- Simultaneous exc_req and eret_req: exc_req wins.
- Simultaneous redirect_valid and exc_req: exc_req wins.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge.
- im_addr must never be registered inside this block. The BRAM is the only registered stage on the instruction path, giving 1-cycle fetch latency.

Test Plan:
- Reset low 3 cycles, then release with f_en=1 → pc_f goes 0x3000, 0x3004, 0x3008 on successive cycles; pc8_f = pc_f + 8; instr_f matches the preloaded BRAM words; cause_f = 0.
- At pc_f = 0x3008, drop f_en for 2 cycles → pc_f holds 0x3008 and instr_f stays stable; resumes at 0x300C.
- redirect_valid=1, redirect_pc=0x3100 with f_en=1 → next pc_f = 0x3100 and instr_f = word at 0x3100. Same with f_en=0 → pc_f holds, redirect ignored.
- redirect_pc=0x3002 → pc_f = 0x3002, instr_f = 0, cause_f = 0x10. Also redirect_pc=0x2FFC → cause_f = 0x10, then pc_f increments to 0x3000 and cause_f = 0.
- exc_req=1 together with f_en=0 and redirect_valid=1 → pc_f = 0x4180. exc_req and eret_req together → 0x4180.
- eret_req=1, epc=0x3040 → pc_f = 0x3040 and instr_f = word at 0x3040. Assert rst=0 in the same cycle → pc_f = 0x3000.
